match_sequencer: RTL and testbench
==================================

Name: match_sequencer

Overview:
- Match-level controller for the handball/ping-pong rally engine (the LED ball datapath).
- Owns the scoreboard, decides who serves, and starts each rally with a one-cycle start pulse.
- Freezes play for a visible pause after each point and declares the match winner.
- The rally engine only moves the ball and reports which side scored.

Parameters:
WIN_POINTS, 11, points needed to win; legal range 2..15.
SERVE_ROTATE, 2, points per server before serve passes; legal range 1..7.
PAUSE_TICKS, 8, tick_en pulses held in POINT_PAUSE; legal range 1..255.
SCORE_W, 5, score counter width; must hold 2*WIN_POINTS-1.

Ports:
clk_game  in  1  game clock; all logic on rising edge.
rst_n  in  1  asynchronous, active-low reset.
tick_en  in  1  one-cycle slow tick used for pause timing.
left_sw  in  1  left player switch, level, synchronous to clk_game.
right_sw  in  1  right player switch, level, synchronous to clk_game.
new_match  in  1  one-cycle pulse: clear scores and restart from any state.
point_left  in  1  pulse from rally engine: left side scored.
point_right  in  1  pulse from rally engine: right side scored.
rally_start  out  1  one-cycle pulse that launches the ball.
serve_left  out  1  1 = left player serves the current/next rally.
play_freeze  out  1  1 while not in RALLY; rally engine holds the ball.
score_left  out  SCORE_W  left score.
score_right  out  SCORE_W  right score.
match_over  out  1  high in MATCH_OVER.
winner_left  out  1  valid while match_over; 1 = left won.

Behaviour:
- Reset (rst_n low, async):
  - state = SERVE_WAIT; scores = 0; serve_left = 1; serve_cnt = 0.
  - pause_cnt = 0; rally_start = 0; play_freeze = 1; match_over = 0; winner_left = 0.
- States: SERVE_WAIT, RALLY, POINT_PAUSE, MATCH_OVER.
- Switch handling: internal registered rising-edge detect on left_sw and right_sw. A held switch never produces a second edge.
- SERVE_WAIT:
  - A rising edge on the current server's switch moves state to RALLY on the next clock.
  - rally_start is high for exactly that first RALLY cycle.
  - An edge from the non-server is ignored.
- RALLY:
  - Exactly one of point_left/point_right is high: on the next clock the scorer's score increments, state moves to POINT_PAUSE, and pause_cnt loads PAUSE_TICKS.
  - Win check uses the post-increment scores and is latched in the same cycle. Win condition: scorer >= WIN_POINTS and lead >= 2, or scorer == 2*WIN_POINTS-1 (hard cap, lead >= 1 suffices).
  - Both points high in the same cycle counts as a let: no score change, no serve rotation, state moves to POINT_PAUSE.
- Point pulses outside RALLY are ignored.
- Serve rotation, applied in the scoring cycle:
  - serve_cnt increments.
  - If serve_cnt reaches SERVE_ROTATE, or deuce is in effect (both post-increment scores >= WIN_POINTS-1), serve_left toggles and serve_cnt clears.
  - No rotation when the point wins the match.
- POINT_PAUSE:
  - pause_cnt decrements on each tick_en.
  - When a tick_en arrives with pause_cnt == 1: go to MATCH_OVER if the win is latched, else to SERVE_WAIT.
  - Minimum pause is therefore PAUSE_TICKS ticks.
- MATCH_OVER:
  - winner_left set from the latched winner; scores held; switches ignored.
  - Exit only via new_match or reset.
- new_match:
  - Has priority over every other event in the same cycle.
  - Next state equals the reset state; the scores, serve_cnt and serve_left values also equal their reset values.
- Reset asserted mid-rally: outputs go to reset values immediately. No rally_start is generated on release.
- Outputs are registered except play_freeze, which is decoded from state (state != RALLY).
- Scores never wrap; the hard cap guarantees SCORE_W suffices.

Decomposition:
- Shared package handball_pkg holds:
  - state enum (2-bit);
  - the WIN_POINTS, SCORE_W and PAUSE_TICKS defaults;
  - a function computing the win condition, reused by the scoreboard display logic.
- One sub-module, sw_edge: a 1-bit registered rising-edge detector with async active-low reset, instantiated twice.
- Everything else is flat in match_sequencer.

Test Plan:
Bench parameters: WIN_POINTS=3, SERVE_ROTATE=2, PAUSE_TICKS=2.
1. Reset, then left_sw rise → rally_start high exactly one cycle, serve_left=1, play_freeze=0. A right_sw rise in SERVE_WAIT beforehand → no rally_start.
2. In RALLY, point_right → score_right=1 next cycle, play_freeze=1. SERVE_WAIT re-entered only after the 2nd tick_en. Second point_right → serve_left=0.
3. Deuce: drive scores to 2-2 → serve toggles each point. 3-2 is not a win. 4-2 → match_over=1, winner_left=1 after pause. Also check a cap run: 5-4 ends the match.
4. point_left and point_right in the same cycle during RALLY → scores unchanged, serve unchanged, POINT_PAUSE entered.
5. Switch held high across SERVE_WAIT entry → no rally_start until released and pressed again. Point pulses in SERVE_WAIT → no score change.
6. new_match in MATCH_OVER and mid-RALLY, plus rst_n low mid-RALLY → scores 0, serve_left=1, state SERVE_WAIT, no spurious rally_start.

Source files
------------

// File: rtl/handball_pkg.sv
// Shared types, defaults and scoring rules
// for the handball match sequencer.
package handball_pkg;

   typedef enum logic [1:0] {
      SERVE_WAIT  = 2'd0,
      RALLY       = 2'd1,
      POINT_PAUSE = 2'd2,
      MATCH_OVER  = 2'd3
   } state_e;

   localparam int WIN_POINTS_DEF   = 11;
   localparam int SERVE_ROTATE_DEF = 2;
   localparam int PAUSE_TICKS_DEF  = 8;
   localparam int SCORE_W_DEF      = 5;

   // Two-point lead past the target, or the hard cap
   // at 2*win-1 where a single point of lead is enough.
   function automatic logic is_win(
      input logic [7:0] scorer,
      input logic [7:0] other,
      input logic [7:0] win_pts
   );
      logic [8:0] s;
      logic [8:0] o;
      logic [8:0] cap;
      s   = {1'b0, scorer};
      o   = {1'b0, other};
      cap = {win_pts, 1'b0} - 9'd1;
      return ((s >= {1'b0, win_pts}) &&
              (s >= o + 9'd2)) ||
             (s == cap);
   endfunction

endpackage

// File: rtl/sw_edge.sv
// Registered rising-edge detector for a
// player switch already synchronous to clk.
module sw_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic sw,
   output logic rise
);

   logic sw_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_q <= 1'b0;
      end else begin
         sw_q <= sw;
      end
   end

   assign rise = sw & ~sw_q;

endmodule

// File: rtl/match_sequencer.sv
// Match-level controller: serve, score,
// pause after each point, declare winner.
module match_sequencer
   import handball_pkg::*;
#(
   parameter int WIN_POINTS   = WIN_POINTS_DEF,
   parameter int SERVE_ROTATE = SERVE_ROTATE_DEF,
   parameter int PAUSE_TICKS  = PAUSE_TICKS_DEF,
   parameter int SCORE_W      = SCORE_W_DEF
) (
   input  logic               clk_game,
   input  logic               rst_n,
   input  logic               tick_en,
   input  logic               left_sw,
   input  logic               right_sw,
   input  logic               new_match,
   input  logic               point_left,
   input  logic               point_right,
   output logic               rally_start,
   output logic               serve_left,
   output logic               play_freeze,
   output logic [SCORE_W-1:0] score_left,
   output logic [SCORE_W-1:0] score_right,
   output logic               match_over,
   output logic               winner_left
);

   localparam logic [7:0] WIN8 = 8'(WIN_POINTS);
   localparam logic [7:0] PAUSE_LD = 8'(PAUSE_TICKS);
   localparam logic [2:0] ROT = 3'(SERVE_ROTATE);
   localparam logic [SCORE_W-1:0] DEUCE_AT =
      SCORE_W'(WIN_POINTS - 1);

   state_e state;
   state_e state_nx;

   logic [SCORE_W-1:0] score_l_q;
   logic [SCORE_W-1:0] score_l_nx;
   logic [SCORE_W-1:0] score_r_q;
   logic [SCORE_W-1:0] score_r_nx;
   logic [SCORE_W-1:0] new_l;
   logic [SCORE_W-1:0] new_r;

   logic       serve_q;
   logic       serve_nx;
   logic [2:0] scnt_q;
   logic [2:0] scnt_nx;
   logic [2:0] scnt_inc;
   logic [7:0] pcnt_q;
   logic [7:0] pcnt_nx;

   logic win_q;
   logic win_nx;
   logic win_left_q;
   logic win_left_nx;
   logic start_q;
   logic start_nx;
   logic over_q;
   logic over_nx;
   logic winner_q;
   logic winner_nx;

   logic left_rise;
   logic right_rise;
   logic server_rise;
   logic one_point;
   logic let_point;
   logic point_win;
   logic deuce;

   sw_edge u_edge_left (
      .clk   (clk_game),
      .rst_n (rst_n),
      .sw    (left_sw),
      .rise  (left_rise)
   );

   sw_edge u_edge_right (
      .clk   (clk_game),
      .rst_n (rst_n),
      .sw    (right_sw),
      .rise  (right_rise)
   );

   assign server_rise = serve_q ? left_rise : right_rise;
   assign one_point   = point_left ^ point_right;
   assign let_point   = point_left & point_right;

   assign new_l = (point_left && !point_right) ?
                  score_l_q + 1'b1 : score_l_q;
   assign new_r = (point_right && !point_left) ?
                  score_r_q + 1'b1 : score_r_q;

   assign point_win = point_left ?
      is_win(8'(new_l), 8'(new_r), WIN8) :
      is_win(8'(new_r), 8'(new_l), WIN8);

   assign deuce = (new_l >= DEUCE_AT) &&
                  (new_r >= DEUCE_AT);
   assign scnt_inc = scnt_q + 3'd1;

   always_ff @(posedge clk_game or negedge rst_n) begin
      if (!rst_n) begin
         state      <= SERVE_WAIT;
         score_l_q  <= '0;
         score_r_q  <= '0;
         serve_q    <= 1'b1;
         scnt_q     <= '0;
         pcnt_q     <= '0;
         win_q      <= 1'b0;
         win_left_q <= 1'b0;
         start_q    <= 1'b0;
         over_q     <= 1'b0;
         winner_q   <= 1'b0;
      end else begin
         state      <= state_nx;
         score_l_q  <= score_l_nx;
         score_r_q  <= score_r_nx;
         serve_q    <= serve_nx;
         scnt_q     <= scnt_nx;
         pcnt_q     <= pcnt_nx;
         win_q      <= win_nx;
         win_left_q <= win_left_nx;
         start_q    <= start_nx;
         over_q     <= over_nx;
         winner_q   <= winner_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      score_l_nx  = score_l_q;
      score_r_nx  = score_r_q;
      serve_nx    = serve_q;
      scnt_nx     = scnt_q;
      pcnt_nx     = pcnt_q;
      win_nx      = win_q;
      win_left_nx = win_left_q;
      start_nx    = 1'b0;
      over_nx     = over_q;
      winner_nx   = winner_q;

      unique case (state)
         SERVE_WAIT: begin
            if (server_rise) begin
               state_nx = RALLY;
               start_nx = 1'b1;
            end
         end
         RALLY: begin
            if (let_point) begin
               state_nx = POINT_PAUSE;
               pcnt_nx  = PAUSE_LD;
            end else if (one_point) begin
               state_nx   = POINT_PAUSE;
               pcnt_nx    = PAUSE_LD;
               score_l_nx = new_l;
               score_r_nx = new_r;
               // The winning point keeps the serve as-is.
               if (point_win) begin
                  win_nx      = 1'b1;
                  win_left_nx = point_left;
               end else if (scnt_inc == ROT || deuce) begin
                  serve_nx = ~serve_q;
                  scnt_nx  = '0;
               end else begin
                  scnt_nx = scnt_inc;
               end
            end
         end
         POINT_PAUSE: begin
            if (tick_en) begin
               pcnt_nx = pcnt_q - 8'd1;
               if (pcnt_q == 8'd1) begin
                  if (win_q) begin
                     state_nx  = MATCH_OVER;
                     over_nx   = 1'b1;
                     winner_nx = win_left_q;
                  end else begin
                     state_nx = SERVE_WAIT;
                  end
               end
            end
         end
         MATCH_OVER: begin
            state_nx = MATCH_OVER;
         end
         default: begin
            state_nx = SERVE_WAIT;
         end
      endcase

      if (new_match) begin
         state_nx    = SERVE_WAIT;
         score_l_nx  = '0;
         score_r_nx  = '0;
         serve_nx    = 1'b1;
         scnt_nx     = '0;
         pcnt_nx     = '0;
         win_nx      = 1'b0;
         win_left_nx = 1'b0;
         start_nx    = 1'b0;
         over_nx     = 1'b0;
         winner_nx   = 1'b0;
      end
   end

   assign rally_start = start_q;
   assign serve_left  = serve_q;
   assign play_freeze = (state != RALLY);
   assign score_left  = score_l_q;
   assign score_right = score_r_q;
   assign match_over  = over_q;
   assign winner_left = winner_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Scoreboard bench for match_sequencer with
// WIN_POINTS=3, SERVE_ROTATE=2, PAUSE_TICKS=2.
module tb_match_sequencer;

   localparam int WP = 3;
   localparam int SR = 2;
   localparam int PT = 2;
   localparam int SW = 5;

   localparam logic [1:0] EV_START = 2'd0;
   localparam logic [1:0] EV_FRZ   = 2'd1;
   localparam logic [1:0] EV_OVER  = 2'd2;
   localparam logic [1:0] EV_END   = 2'd3;

   logic clk_game = 1'b0;
   logic rst_n = 1'b0;
   logic tick_en = 1'b0;
   logic left_sw = 1'b0;
   logic right_sw = 1'b0;
   logic new_match = 1'b0;
   logic point_left = 1'b0;
   logic point_right = 1'b0;
   logic rally_start;
   logic serve_left;
   logic play_freeze;
   logic match_over;
   logic winner_left;
   logic [SW-1:0] score_left;
   logic [SW-1:0] score_right;

   always #5 clk_game = ~clk_game;

   match_sequencer #(
      .WIN_POINTS   (WP),
      .SERVE_ROTATE (SR),
      .PAUSE_TICKS  (PT),
      .SCORE_W      (SW)
   ) dut (
      .clk_game    (clk_game),
      .rst_n       (rst_n),
      .tick_en     (tick_en),
      .left_sw     (left_sw),
      .right_sw    (right_sw),
      .new_match   (new_match),
      .point_left  (point_left),
      .point_right (point_right),
      .rally_start (rally_start),
      .serve_left  (serve_left),
      .play_freeze (play_freeze),
      .score_left  (score_left),
      .score_right (score_right),
      .match_over  (match_over),
      .winner_left (winner_left)
   );

   typedef struct packed {
      logic [1:0] kind;
      logic       sl;
      logic [4:0] l;
      logic [4:0] r;
      logic       mo;
      logic       wl;
   } ev_t;

   ev_t exp_q[$];
   int checks = 0;
   int errors = 0;
   logic prev_freeze = 1'b1;
   logic prev_mo = 1'b0;

   task automatic expect_ev(
      input logic [1:0] k, input logic sl,
      input int l, input int r,
      input logic mo, input logic wl
   );
      ev_t e;
      e.kind = k;
      e.sl = sl;
      e.l = 5'(l);
      e.r = 5'(r);
      e.mo = mo;
      e.wl = wl;
      exp_q.push_back(e);
   endtask

   task automatic check_ev(input logic [1:0] k);
      ev_t g;
      ev_t e;
      g.kind = k;
      g.sl = serve_left;
      g.l = score_left;
      g.r = score_right;
      g.mo = match_over;
      g.wl = winner_left;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event t=%0t got kind=%0d sl=%0b %0d-%0d mo=%0b wl=%0b",
            $time, g.kind, g.sl, g.l, g.r, g.mo, g.wl);
      end else begin
         e = exp_q.pop_front();
         if (g !== e) begin
            errors++;
            $display("FAIL event t=%0t got kind=%0d sl=%0b %0d-%0d mo=%0b wl=%0b, expected kind=%0d sl=%0b %0d-%0d mo=%0b wl=%0b",
               $time, g.kind, g.sl, g.l, g.r, g.mo, g.wl,
               e.kind, e.sl, e.l, e.r, e.mo, e.wl);
         end
      end
   endtask

   always @(negedge clk_game) begin
      if (rally_start === 1'b1)
         check_ev(EV_START);
      if (prev_freeze === 1'b0 && play_freeze === 1'b1)
         check_ev(EV_FRZ);
      if (prev_mo === 1'b0 && match_over === 1'b1)
         check_ev(EV_OVER);
      if (prev_mo === 1'b1 && match_over === 1'b0)
         check_ev(EV_END);
      prev_freeze <= play_freeze;
      prev_mo <= match_over;
   end

   task automatic chk(
      input string nm, input logic [7:0] got,
      input logic [7:0] exp
   );
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d",
            nm, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk_game);
         #1;
      end
   endtask

   task automatic wait_drain(input string nm);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk_game);
         #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s timeout got %0d pending expected 0",
            nm, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic pulse_point(input logic pl, input logic pr);
      @(posedge clk_game);
      #1;
      point_left = pl;
      point_right = pr;
      @(posedge clk_game);
      #1;
      point_left = 1'b0;
      point_right = 1'b0;
   endtask

   task automatic pulse_nm();
      @(posedge clk_game);
      #1;
      new_match = 1'b1;
      @(posedge clk_game);
      #1;
      new_match = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         @(posedge clk_game);
         #1;
         tick_en = 1'b1;
         @(posedge clk_game);
         #1;
         tick_en = 1'b0;
      end
   endtask

   task automatic press(input logic left);
      @(posedge clk_game);
      #1;
      if (left) left_sw = 1'b1;
      else right_sw = 1'b1;
      cyc(2);
      left_sw = 1'b0;
      right_sw = 1'b0;
      cyc(1);
   endtask

   task automatic serve(
      input logic sl, input int l, input int r
   );
      expect_ev(EV_START, sl, l, r, 1'b0, 1'b0);
      press(sl);
      wait_drain("serve");
   endtask

   task automatic rally_point(
      input logic pl, input logic pr,
      input logic sl, input int l, input int r,
      input logic win, input logic wl
   );
      expect_ev(EV_FRZ, sl, l, r, 1'b0, 1'b0);
      pulse_point(pl, pr);
      wait_drain("point");
      if (win) expect_ev(EV_OVER, sl, l, r, 1'b1, wl);
      ticks(2);
      wait_drain("pause");
      if (!win) serve(sl, l, r);
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_start"}, 8'(rally_start), 8'd0);
      chk({nm, "_serve"}, 8'(serve_left), 8'd1);
      chk({nm, "_freeze"}, 8'(play_freeze), 8'd1);
      chk({nm, "_sl"}, 8'(score_left), 8'd0);
      chk({nm, "_sr"}, 8'(score_right), 8'd0);
      chk({nm, "_over"}, 8'(match_over), 8'd0);
      chk({nm, "_win"}, 8'(winner_left), 8'd0);
   endtask

   // Cap run: R R L L R L R L R, ending 4-5.
   int cap_pl[9] = '{0, 0, 1, 1, 0, 1, 0, 1, 0};
   int cap_sl[9] = '{1, 0, 0, 1, 0, 1, 0, 1, 1};
   int cap_l[9]  = '{0, 0, 1, 2, 2, 3, 3, 4, 4};
   int cap_r[9]  = '{1, 2, 2, 2, 3, 3, 4, 4, 5};

   initial begin
      cyc(3);
      rst_n = 1'b1;
      cyc(1);
      chk_reset_vals("reset");

      press(1'b0);
      cyc(3);
      serve(1'b1, 0, 0);
      chk("rally_freeze", 8'(play_freeze), 8'd0);

      expect_ev(EV_FRZ, 1'b1, 0, 1, 1'b0, 1'b0);
      pulse_point(1'b0, 1'b1);
      wait_drain("first_point");
      ticks(1);
      press(1'b1);
      ticks(1);
      serve(1'b1, 0, 1);

      rally_point(1'b0, 1'b1, 1'b0, 0, 2, 1'b0, 1'b0);
      rally_point(1'b1, 1'b0, 1'b0, 1, 2, 1'b0, 1'b0);
      rally_point(1'b1, 1'b0, 1'b1, 2, 2, 1'b0, 1'b0);
      rally_point(1'b1, 1'b0, 1'b0, 3, 2, 1'b0, 1'b0);
      rally_point(1'b1, 1'b0, 1'b0, 4, 2, 1'b1, 1'b1);

      press(1'b1);
      press(1'b0);
      pulse_point(1'b0, 1'b1);
      cyc(3);
      chk("over_hold_l", 8'(score_left), 8'd4);
      chk("over_hold_r", 8'(score_right), 8'd2);

      expect_ev(EV_END, 1'b1, 0, 0, 1'b0, 1'b0);
      pulse_nm();
      wait_drain("nm_over");
      serve(1'b1, 0, 0);

      rally_point(1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);

      for (int i = 0; i < 9; i++) begin
         rally_point(
            logic'(cap_pl[i]), logic'(cap_pl[i] == 0),
            logic'(cap_sl[i]), cap_l[i], cap_r[i],
            logic'(i == 8), 1'b0);
      end

      expect_ev(EV_END, 1'b1, 0, 0, 1'b0, 1'b0);
      pulse_nm();
      wait_drain("nm_cap");
      serve(1'b1, 0, 0);

      @(posedge clk_game);
      #1;
      left_sw = 1'b1;
      expect_ev(EV_FRZ, 1'b1, 1, 0, 1'b0, 1'b0);
      pulse_point(1'b1, 1'b0);
      wait_drain("held_point");
      ticks(2);
      cyc(5);
      pulse_point(1'b1, 1'b0);
      pulse_point(1'b0, 1'b1);
      cyc(2);
      chk("idle_pt_l", 8'(score_left), 8'd1);
      chk("idle_pt_r", 8'(score_right), 8'd0);
      left_sw = 1'b0;
      cyc(2);
      serve(1'b1, 1, 0);

      expect_ev(EV_FRZ, 1'b1, 0, 0, 1'b0, 1'b0);
      pulse_nm();
      wait_drain("nm_rally");
      cyc(4);
      serve(1'b1, 0, 0);
      rally_point(1'b0, 1'b1, 1'b1, 0, 1, 1'b0, 1'b0);

      expect_ev(EV_FRZ, 1'b1, 0, 0, 1'b0, 1'b0);
      @(posedge clk_game);
      #1;
      rst_n = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      wait_drain("rst_rally");
      cyc(5);
      chk_reset_vals("rst_mid");
      serve(1'b1, 0, 0);

      cyc(3);
      $display("End of test - %0d assertions evaluated, %0d failures",
         checks, errors);
      $finish;
   end

endmodule
